// File: rtl/argmax_classifier.sv
// argmax_classifier
// Scans a ROWS x COLS row-major signed matrix Z through a synchronous read
// port. For each row it writes the column index of the largest value into a
// result RAM. Ties resolve to the lowest column. A single-cycle done pulse
// marks the end of the scan.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begins a scan when sampled high in IDLE
//   z_data    Z RAM read data, valid one cycle after z_addr
//   z_addr    Z RAM read address (registered)
//   res_addr  result RAM write address = row number (registered)
//   res_data  argmax column index of the row (registered)
//   res_wen   result RAM write strobe, one cycle per row
//   busy      high from the first FETCH cycle through the final WRITE cycle
//   res_score (only with ARGMAX_SCORE_OUT_EN) winning value, same timing as res_data
//   done      one-cycle pulse in the cycle after the last res_wen
//
// Optional feature macro: ARGMAX_SCORE_OUT_EN
module argmax_classifier #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROWS       = 5,
    parameter int unsigned COLS       = 5,
    parameter int unsigned IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] z_data,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [ADDR_WIDTH-1:0] res_addr,
    output logic [IDX_WIDTH-1:0]  res_data,
    output logic                  res_wen,
    output logic                  busy,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic [DATA_WIDTH-1:0] res_score,
`endif
    output logic                  done
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [ROW_W-1:0]      r_row,      w_row_nxt;
    logic [COL_W-1:0]      r_col,      w_col_nxt;
    logic                  r_rd_vld,   w_rd_vld_nxt;
    logic [COL_W-1:0]      r_rd_col,   w_rd_col_nxt;
    logic [DATA_WIDTH-1:0] r_best_val, w_best_val;
    logic [COL_W-1:0]      r_best_idx, w_best_idx;
    logic [ADDR_WIDTH-1:0] r_z_addr,   w_z_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_res_addr, w_res_addr_nxt;
    logic [IDX_WIDTH-1:0]  r_res_data, w_res_data_nxt;
    logic                  r_res_wen,  w_res_wen_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_done,     w_done_nxt;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [DATA_WIDTH-1:0] r_res_score, w_res_score_nxt;
`endif

    // Running max: r_rd_col tags which column the returning read data belongs to.
    always_comb begin
        w_best_val = r_best_val;
        w_best_idx = r_best_idx;
        if (r_rd_vld) begin
            if (r_rd_col == '0) begin
                w_best_val = z_data;
                w_best_idx = '0;
            end else if ($signed(z_data) > $signed(r_best_val)) begin
                w_best_val = z_data;
                w_best_idx = r_rd_col;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_col_nxt       = r_col;
        w_rd_vld_nxt    = 1'b0;
        w_rd_col_nxt    = r_rd_col;
        w_z_addr_nxt    = r_z_addr;
        w_res_addr_nxt  = r_res_addr;
        w_res_data_nxt  = r_res_data;
        w_res_wen_nxt   = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
        w_res_score_nxt = r_res_score;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_z_addr_nxt = '0;
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = FETCH;
                end
            end
            FETCH: begin
                w_rd_vld_nxt = 1'b1;
                w_rd_col_nxt = r_col;
                if (r_col != COL_W'(COLS - 1)) begin
                    w_col_nxt    = r_col + COL_W'(1);
                    w_z_addr_nxt = r_z_addr + ADDR_WIDTH'(1);
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last element's compare is folded in combinationally here.
                w_res_wen_nxt   = 1'b1;
                w_res_addr_nxt  = ADDR_WIDTH'(r_row);
                w_res_data_nxt  = IDX_WIDTH'(w_best_idx);
`ifdef ARGMAX_SCORE_OUT_EN
                w_res_score_nxt = w_best_val;
`endif
                w_state_nxt     = WRITE;
            end
            WRITE: begin
                if (r_row == ROW_W'(ROWS - 1)) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_row_nxt    = r_row + ROW_W'(1);
                    w_col_nxt    = '0;
                    // z_addr still holds row*COLS+COLS-1, so +1 is (row+1)*COLS.
                    w_z_addr_nxt = r_z_addr + ADDR_WIDTH'(1);
                    w_state_nxt  = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_col    <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_z_addr    <= '0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
            r_res_wen   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
            r_res_score <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_rd_vld    <= w_rd_vld_nxt;
            r_rd_col    <= w_rd_col_nxt;
            r_best_val  <= w_best_val;
            r_best_idx  <= w_best_idx;
            r_z_addr    <= w_z_addr_nxt;
            r_res_addr  <= w_res_addr_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_wen   <= w_res_wen_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
`ifdef ARGMAX_SCORE_OUT_EN
            r_res_score <= w_res_score_nxt;
`endif
        end
    end

    assign z_addr    = r_z_addr;
    assign res_addr  = r_res_addr;
    assign res_data  = r_res_data;
    assign res_wen   = r_res_wen;
    assign busy      = r_busy;
    assign done      = r_done;
`ifdef ARGMAX_SCORE_OUT_EN
    assign res_score = r_res_score;
`endif

endmodule
